// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
//   div_state_e        : FSM encoding (IDLE, CALC, FIXUP, DONE)
//   DIV_WIDTH_DEFAULT  : default divisor/quotient/remainder width
//   sat_max / sat_min  : saturation magnitudes for a W-bit signed result,
//                        returned zero-extended in 64 bits (caller truncates)
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 16;

  // 2^(w-1)-1 : most positive W-bit signed value
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // 2^(w-1) : bit pattern (and magnitude) of the most negative W-bit value
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/divs_signfix.sv
// Combinational magnitude-to-signed fixup for the divider.
// Takes the 2*WIDTH-bit magnitude quotient and WIDTH-bit magnitude
// remainder plus the two result signs, decides saturation and produces the
// signed results.
//   q_mag_i      : magnitude quotient (2*WIDTH bits)
//   r_mag_i      : magnitude remainder (always < 2^(WIDTH-1))
//   q_neg_i      : quotient is negative
//   r_neg_i      : remainder is negative (follows dividend sign)
//   quotient_o   : signed quotient, saturated on overflow
//   remainder_o  : signed remainder, zero on overflow
//   overflow_o   : quotient did not fit in WIDTH signed bits
module divs_signfix
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [2*WIDTH-1:0] q_mag_i,
  input  logic [WIDTH-1:0]   r_mag_i,
  input  logic               q_neg_i,
  input  logic               r_neg_i,
  output logic [WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]   remainder_o,
  output logic               overflow_o
);

  localparam logic [2*WIDTH-1:0] POS_LIM = (2*WIDTH)'(sat_max(WIDTH));
  localparam logic [2*WIDTH-1:0] NEG_LIM = (2*WIDTH)'(sat_min(WIDTH));
  localparam logic [WIDTH-1:0]   Q_MAX   = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0]   Q_MIN   = WIDTH'(sat_min(WIDTH));

  always_comb begin
    // A negative result may reach magnitude 2^(WIDTH-1); a positive one
    // may only reach 2^(WIDTH-1)-1.
    overflow_o  = q_neg_i ? (q_mag_i > NEG_LIM) : (q_mag_i > POS_LIM);
    quotient_o  = '0;
    remainder_o = '0;
    if (overflow_o) begin
      quotient_o  = q_neg_i ? Q_MIN : Q_MAX;
      remainder_o = '0;
    end else begin
      // Negating 2^(WIDTH-1) in WIDTH bits yields the same pattern, which
      // is exactly the most negative value we want.
      quotient_o  = q_neg_i ? -q_mag_i[WIDTH-1:0] : q_mag_i[WIDTH-1:0];
      remainder_o = r_neg_i ? -r_mag_i : r_mag_i;
    end
  end

endmodule

// File: rtl/div32s16_seq.sv
// Sequential signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor ->
// WIDTH-bit quotient (truncated toward zero) and remainder (sign of the
// dividend). Radix-2 restoring division on magnitudes, one quotient bit per
// cycle, followed by a sign fixup / saturation cycle.
//
// Optional feature macro: DIV_EARLY_SMALL_EN -- when defined, operations
// with |dividend| < |divisor| complete on the accept edge (quotient 0,
// remainder = dividend). Results are identical either way.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE and the
// result outputs hold steady until the out_valid && out_ready edge.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake
//   dividend, divisor     : signed operands (2*WIDTH, WIDTH bits)
//   out_valid / out_ready : result handshake
//   quotient, remainder   : signed results (WIDTH bits)
//   overflow              : quotient saturated
//   div_by_zero           : divisor was zero
//   dbg_state             : current FSM state
module div32s16_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               overflow,
  output logic               div_by_zero,
  output div_state_e         dbg_state
);

  localparam int             CW    = $clog2(2*WIDTH);
  localparam logic [CW-1:0]  LAST  = CW'(2*WIDTH-1);
  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] Q_MIN = WIDTH'(sat_min(WIDTH));

  div_state_e         state_q;
  logic [2*WIDTH-1:0] dvd_q;    // dividend magnitude, shifted out MSB first
  logic [WIDTH:0]     dvs_q;    // divisor magnitude; 2^(WIDTH-1) needs the extra bit
  logic [WIDTH-1:0]   prem_q;   // partial remainder, always < |divisor|
  logic [2*WIDTH-1:0] quo_q;    // magnitude quotient
  logic [CW-1:0]      cnt_q;
  logic               qneg_q;
  logic               rneg_q;

  logic [2*WIDTH-1:0] dvd_abs;
  logic [WIDTH:0]     dvs_abs;
  logic               dvs_zero;
  logic               small_d;
  logic [WIDTH:0]     prem_sh_d;
  logic [WIDTH:0]     trial_d;
  logic [WIDTH-1:0]   prem_d;
  logic [WIDTH-1:0]   sf_q;
  logic [WIDTH-1:0]   sf_r;
  logic               sf_ovf;

  // Negating the most negative dividend gives 2^(2W-1), which is exact as
  // an unsigned 2W-bit value.
  assign dvd_abs  = dividend[2*WIDTH-1] ? -dividend : dividend;
  assign dvs_abs  = divisor[WIDTH-1] ? -{1'b1, divisor} : {1'b0, divisor};
  assign dvs_zero = (divisor == '0);

`ifdef DIV_EARLY_SMALL_EN
  assign small_d = (dvd_abs < {{(WIDTH-1){1'b0}}, dvs_abs});
`else
  assign small_d = 1'b0;
`endif

  // One restoring step: the shifted remainder is < 2^WIDTH and the divisor
  // magnitude <= 2^(WIDTH-1), so the trial difference fits WIDTH+1 bits and
  // its MSB is a clean "negative, restore" flag.
  assign prem_sh_d = {prem_q, dvd_q[2*WIDTH-1]};
  assign trial_d   = prem_sh_d - dvs_q;
  assign prem_d    = trial_d[WIDTH] ? prem_sh_d[WIDTH-1:0] : trial_d[WIDTH-1:0];

  divs_signfix #(.WIDTH(WIDTH)) u_signfix (
    .q_mag_i     (quo_q),
    .r_mag_i     (prem_q),
    .q_neg_i     (qneg_q),
    .r_neg_i     (rneg_q),
    .quotient_o  (sf_q),
    .remainder_o (sf_r),
    .overflow_o  (sf_ovf)
  );

  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q  <= dvd_abs;
            dvs_q  <= dvs_abs;
            qneg_q <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q <= dividend[2*WIDTH-1];
            prem_q <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            in_ready <= 1'b0;
            if (dvs_zero) begin
              quotient    <= dividend[2*WIDTH-1] ? Q_MIN : Q_MAX;
              remainder   <= dividend[WIDTH-1:0];
              overflow    <= 1'b0;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state_q     <= DONE;
            end else if (small_d) begin
              quotient    <= '0;
              remainder   <= dividend[WIDTH-1:0];
              overflow    <= 1'b0;
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= prem_d;
          dvd_q  <= {dvd_q[2*WIDTH-2:0], 1'b0};
          quo_q  <= {quo_q[2*WIDTH-2:0], ~trial_d[WIDTH]};
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= FIXUP;
        end
        FIXUP: begin
          quotient    <= sf_q;
          remainder   <= sf_r;
          overflow    <= sf_ovf;
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32s16_seq.sv
// Directed bench for div32s16_seq: a table of hand-computed vectors applied
// in a loop, followed by hand-written backpressure and mid-operation reset
// sequences, and a few direct vectors on the sign-fixup block.
// Latency is counted in rising edges with the accept edge as edge 1.
module tb_div32s16_seq;
  import div_pkg::*;

  localparam int W = 16;
`ifdef DIV_EARLY_SMALL_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 34;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           overflow;
  logic           div_by_zero;
  div_state_e     dbg_state;

  // sign-fixup reference instance
  logic [2*W-1:0] sf_mag;
  logic [W-1:0]   sf_rem;
  logic           sf_qneg;
  logic           sf_rneg;
  logic [W-1:0]   sf_q;
  logic [W-1:0]   sf_r;
  logic           sf_ovf;

  int checks = 0;
  int errors = 0;

  div32s16_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  divs_signfix #(.WIDTH(W)) u_ref (
    .q_mag_i     (sf_mag),
    .r_mag_i     (sf_rem),
    .q_neg_i     (sf_qneg),
    .r_neg_i     (sf_rneg),
    .quotient_o  (sf_q),
    .remainder_o (sf_r),
    .overflow_o  (sf_ovf)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           ovf;
    logic           dbz;
    int             lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operand pair, then count edges until out_valid (bounded).
  task automatic do_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_result(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_ovalid_drop"}, 32'(out_valid), 32'd0);
    chk({name, "_iready_rise"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{32'd1000,     16'd7,    16'd142,  16'd6,    1'b0, 1'b0, 34};
    vecs[1]  = '{32'hFFFFFC18, 16'd7,    16'hFF72, 16'hFFFA, 1'b0, 1'b0, 34};
    vecs[2]  = '{32'd1000,     16'hFFF9, 16'hFF72, 16'd6,    1'b0, 1'b0, 34};
    vecs[3]  = '{32'hFFFFFC18, 16'hFFF9, 16'd142,  16'hFFFA, 1'b0, 1'b0, 34};
    vecs[4]  = '{32'h7FFFFFFF, 16'd1,    16'h7FFF, 16'd0,    1'b1, 1'b0, 34};
    vecs[5]  = '{32'h80000000, 16'hFFFF, 16'h7FFF, 16'd0,    1'b1, 1'b0, 34};
    vecs[6]  = '{32'hFFFF8000, 16'd1,    16'h8000, 16'd0,    1'b0, 1'b0, 34};
    vecs[7]  = '{32'd5,        16'd0,    16'h7FFF, 16'd5,    1'b0, 1'b1, 1};
    vecs[8]  = '{32'hFFFFFFFB, 16'd0,    16'h8000, 16'hFFFB, 1'b0, 1'b1, 1};
    vecs[9]  = '{32'd3,        16'd7,    16'd0,    16'd3,    1'b0, 1'b0, SMALL_LAT};
    vecs[10] = '{32'hFFFFFFFD, 16'd7,    16'd0,    16'hFFFD, 1'b0, 1'b0, SMALL_LAT};
    vecs[11] = '{32'h00008000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 1'b0, 34};
    vecs[12] = '{32'h00008000, 16'd1,    16'h7FFF, 16'd0,    1'b1, 1'b0, 34};
    vecs[13] = '{32'h40000000, 16'h8000, 16'h8000, 16'd0,    1'b0, 1'b0, 34};
    vecs[14] = '{32'h000186A0, 16'h8000, 16'hFFFD, 16'h06A0, 1'b0, 1'b0, 34};
    vecs[15] = '{32'h80000000, 16'h8000, 16'h7FFF, 16'd0,    1'b1, 1'b0, 34};
    vecs[16] = '{32'hFFFF7FFF, 16'd1,    16'h8000, 16'd0,    1'b1, 1'b0, 34};
    vecs[17] = '{32'h00BC614E, 16'd1000, 16'h3039, 16'h02A6, 1'b0, 1'b0, 34};

    // reset
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    sf_mag    = '0;
    sf_rem    = '0;
    sf_qneg   = 1'b0;
    sf_rneg   = 1'b0;
    #1;
    chk("rst_in_ready",  32'(in_ready),    32'd1);
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    chk("rst_quotient",  32'(quotient),    32'd0);
    chk("rst_remainder", 32'(remainder),   32'd0);
    chk("rst_flags",     {30'd0, overflow, div_by_zero}, 32'd0);
    chk("rst_state",     32'(dbg_state),   32'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // sign-fixup block on its own
    sf_mag = 32'd142; sf_rem = 16'd6; sf_qneg = 1'b1; sf_rneg = 1'b1;
    #1;
    chk("sf0_q", 32'(sf_q), 32'h0000FF72);
    chk("sf0_r", 32'(sf_r), 32'h0000FFFA);
    chk("sf0_ovf", 32'(sf_ovf), 32'd0);
    sf_mag = 32'h00008000; sf_rem = 16'd0; sf_qneg = 1'b1; sf_rneg = 1'b0;
    #1;
    chk("sf1_q", 32'(sf_q), 32'h00008000);
    chk("sf1_ovf", 32'(sf_ovf), 32'd0);
    sf_qneg = 1'b0; sf_rem = 16'd9;
    #1;
    chk("sf2_q", 32'(sf_q), 32'h00007FFF);
    chk("sf2_r", 32'(sf_r), 32'd0);
    chk("sf2_ovf", 32'(sf_ovf), 32'd1);

    // table-driven vectors
    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].dvd, vecs[i].dvs, lat);
      chk($sformatf("v%0d_latency", i),   32'(lat),         32'(vecs[i].lat));
      chk($sformatf("v%0d_quotient", i),  32'(quotient),    32'(vecs[i].q));
      chk($sformatf("v%0d_remainder", i), 32'(remainder),   32'(vecs[i].r));
      chk($sformatf("v%0d_overflow", i),  32'(overflow),    32'(vecs[i].ovf));
      chk($sformatf("v%0d_divzero", i),   32'(div_by_zero), 32'(vecs[i].dbz));
      take_result($sformatf("v%0d", i));
    end

    // backpressure: result held 5 cycles while the next operands wait
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd1000;
    divisor  = 16'd7;
    @(posedge clk);
    #1;
    dividend = 32'hFFFFFFFB;
    divisor  = 16'd0;
    chk("bp_busy_in_ready", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd34);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_in_ready", c),  32'(in_ready),  32'd0);
      chk($sformatf("bp%0d_quotient", c),  32'(quotient),  32'd142);
      chk($sformatf("bp%0d_remainder", c), 32'(remainder), 32'd6);
    end
    take_result("bp_first");
    // the held operands are accepted on the following edge (divide by zero)
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_valid",   32'(out_valid),   32'd1);
    chk("bp_second_q",       32'(quotient),    32'h00008000);
    chk("bp_second_r",       32'(remainder),   32'h0000FFFB);
    chk("bp_second_divzero", 32'(div_by_zero), 32'd1);
    take_result("bp_second");

    // reset while CALC is at step 10
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd1000;
    divisor  = 16'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("mid_state_calc", 32'(dbg_state), 32'(CALC));
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_quotient",  32'(quotient),  32'd0);
    chk("mid_rst_remainder", 32'(remainder), 32'd0);
    chk("mid_rst_flags",     {30'd0, overflow, div_by_zero}, 32'd0);
    chk("mid_rst_state",     32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    do_op(32'd100, 16'hFFFD, lat);
    chk("post_rst_latency",   32'(lat),       32'd34);
    chk("post_rst_quotient",  32'(quotient),  32'h0000FFDF);
    chk("post_rst_remainder", 32'(remainder), 32'd1);
    chk("post_rst_overflow",  32'(overflow),  32'd0);
    take_result("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div32s16_seq.md
Name: div32s16_seq

Overview:
- Sequential signed divider; the inverse of the team's registered 16x16 signed multiplier.
- Takes a 2*WIDTH-bit signed dividend (product-width) and a WIDTH-bit signed divisor, returns a WIDTH-bit quotient and remainder.
- Radix-2 restoring division on magnitudes with sign fixup, saturation and divide-by-zero flags.
- Sits behind valid/ready handshakes on both sides, so it drops into the same datapath benches as the multiplier wrapper.

Parameters:
- WIDTH, 16, divisor/quotient/remainder width; dividend is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  2*WIDTH  signed dividend
- divisor  input  WIDTH  signed divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder, sign follows dividend
- overflow  output  1  quotient saturated
- div_by_zero  output  1  divisor was zero

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; quotient, remainder, overflow and div_by_zero all 0. Any in-flight operation is discarded.
- in_ready is high only in IDLE; there are no skid buffers. Accept occurs on an edge where in_valid && in_ready.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE -> CALC on accept, with divisor != 0:
  - latch |dividend| (2*WIDTH bits) and |divisor|;
  - latch the quotient sign (sign(dividend) xor sign(divisor)) and the remainder sign (sign(dividend));
  - clear the WIDTH+1-bit partial remainder; set step counter = 0.
- IDLE -> DONE on accept, with divisor == 0:
  - div_by_zero=1, overflow=0;
  - quotient = 0x7FFF.. if dividend >= 0, else 0x8000..;
  - remainder = dividend[WIDTH-1:0].
- CALC, one step per cycle, 2*WIDTH steps:
  - shift the next dividend MSB into the partial remainder;
  - trial-subtract |divisor|; restore if the result is negative;
  - shift the quotient bit into a 2*WIDTH-bit magnitude register.
  - After the step with counter = 2*WIDTH-1 -> FIXUP.
- FIXUP, one cycle, -> DONE. Let q = magnitude quotient.
  - Overflow if q > 2^(WIDTH-1)-1 (positive sign) or q > 2^(WIDTH-1) (negative sign).
  - On overflow: overflow=1; quotient = max positive or min negative per sign; remainder=0.
  - Otherwise: quotient = ±q[WIDTH-1:0]; remainder = ±rem. The remainder always fits because |rem| < |divisor| <= 2^(WIDTH-1).
- DONE:
  - out_valid=1; all result outputs held stable while out_ready=0.
  - On out_valid && out_ready -> IDLE; out_valid drops and in_ready rises on the same edge.
  - A new input cannot be accepted in the same cycle as the result handshake (in_ready is still low in DONE).
- Latency: out_valid is high after edge accept+2*WIDTH+2 (34 edges for WIDTH=16). Divide-by-zero: high after the accept edge itself.
- Result outputs are registered and change only on entry to DONE or on reset.
- Corner cases:
  - -2^(2W-1) dividend: magnitude is 2^(2W-1), represented exactly in the unsigned 2W-bit register.
  - divisor = -2^(W-1): |divisor| = 2^(W-1) in the WIDTH+1-bit datapath.

Optional Feature:
- Macro: DIV_EARLY_SMALL_EN.
- Defined: on accept, if |dividend| < |divisor| (and divisor != 0), go directly to DONE with:
  - quotient=0, remainder=dividend[WIDTH-1:0], overflow=0;
  - latency is the same as the divide-by-zero path.
- Undefined: every nonzero-divisor operation takes the full 2*WIDTH+2 latency. The numeric results are identical either way.

Decomposition:
- Package div_pkg holds:
  - state enum div_state_e {IDLE, CALC, FIXUP, DONE};
  - DIV_WIDTH_DEFAULT=16;
  - saturation constant functions sat_max(W) and sat_min(W).
- One sub-module, divs_signfix: combinational magnitude-to-signed fixup with the overflow/saturation decision. It is used in FIXUP and reused by the bench as a reference checker.

Test Plan:
- 1000 / 7 -> quotient=142, remainder=6, flags 0, out_valid exactly 34 edges after accept.
- -1000 / 7 -> quotient=-142 (0xFF72), remainder=-6 (0xFFFA); 1000 / -7 -> quotient=-142, remainder=6.
- 0x7FFFFFFF / 1 -> overflow=1, quotient=0x7FFF, remainder=0; 0x80000000 / -1 -> overflow=1, quotient=0x7FFF; 0xFFFF8000 / 1 -> quotient=0x8000, overflow=0.
- 5 / 0 -> div_by_zero=1, quotient=0x7FFF, remainder=5, out_valid one edge after accept; -5 / 0 -> quotient=0x8000, remainder=0xFFFB.
- Backpressure: out_ready held low 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; in_valid held high is not accepted until the cycle after the result handshake.
- Assert rst mid-CALC at step 10 -> immediately in_ready=1, out_valid=0, all outputs 0; the next operation, 100 / -3, gives quotient=-33, remainder=1.
